cu_vertex_cache_response_merge: RTL
===================================

# cu_vertex_cache_response_merge

Downstream stage of the PageRank PULL vertex cache. Merges the cache-hit stream (response plus two data half-lines) with the memory-read stream that services cache misses into a single in-order-per-source response/data stream for the compute unit. Per-source FIFOs buffer each stream. An arbiter grants one complete transaction per cycle. A fixed response delay guarantees both data halves reach the consumer before their response.

## Interface
**Parameters**
- FIFO_DEPTH, 16: entries per source FIFO; power of two, minimum 4.
- RSP_GAP, 4: cycles between data-out and response-out of the same transaction; minimum 1.

**Ports**
- clock  in  1  sole clock.
- rstn_in  in  1  reset; synchronous, active-low (decided: one clock, sync active-low reset).
- enabled_in  in  1  grant enable; FIFOs still accept pushes when low.
- stall_in  in  1  consumer back-pressure; blocks new grants.
- cache_response_in  in  ResponseBufferLine  hit-path response.
- cache_data_0_in / cache_data_1_in  in  ReadWriteDataLine  hit-path data halves.
- mem_response_in  in  ResponseBufferLine  miss-path response.
- mem_data_0_in / mem_data_1_in  in  ReadWriteDataLine  miss-path data halves.
- read_response_out  out  ResponseBufferLine  merged response.
- read_data_0_out / read_data_1_out  out  ReadWriteDataLine  merged data halves.
- cache_full_out / mem_full_out  out  1  per-source almost-full.
- overflow_out  out  1  sticky push-into-full error.

## Operation
- Each source has three FIFOs: D0, D1, RSP. Each is FIFO_DEPTH deep and holds the full payload. A push occurs on the input's .valid.
- A source is eligible when its D0, D1 and RSP are all non-empty.
- Grant condition: enabled_in=1, stall_in=0, at least one source eligible.
- A grant pops one entry from each of the winner's three FIFOs in the same cycle.
- Arbitration with the macro defined: round-robin. A last-grant bit points to the other source after each grant. After reset the cache source wins first.
- Arbitration with the macro undefined: fixed priority, cache over mem.
- Popped data drives read_data_0_out and read_data_1_out, both valid together.
- The popped response enters an RSP_GAP-stage shift pipeline, then drives read_response_out.
- The shift pipeline always advances. stall_in and enabled_in do not freeze it, so in-flight responses still follow their data.
- Almost-full: *_full_out=1 when any FIFO of that source holds ≥ FIFO_DEPTH−2 entries. The two-entry margin covers upstream latency.
- Push into a full FIFO: the push is dropped, the FIFO is unchanged, and overflow_out sets and holds until reset.
- Simultaneous push and pop on the same FIFO: legal at any occupancy, including full. The count is unchanged.
- Pointers wrap modulo FIFO_DEPTH. Counts are $clog2(FIFO_DEPTH)+1 bits wide.

## Timing
- Reset: clears all FIFO pointers and counts, all output .valid bits, the pipeline valid bits, overflow_out, and the full flags. The round-robin pointer resets to cache. All output payloads reset to 0.
- Reset mid-operation: all buffered and in-flight transactions are discarded. No output valid appears in the cycle after rstn_in is sampled low.
- Latency:
  - A push in cycle T becomes visible to eligibility at T+1.
  - A grant in cycle G gives data valid at G+1 and response valid at G+1+RSP_GAP.
  - Minimum input-to-data latency is therefore 2 cycles (response pushed at T, data at T+2), when D0 and D1 were already present.
- Throughput: one transaction per cycle when unstalled.
- The full flags are registered and update the cycle after the count changes.

## Configuration
- VERTEX_CACHE_MERGE_RR_EN
  - Defined: round-robin arbitration between cache and mem.
  - Undefined: fixed priority to cache; the mem source can starve under continuous hits.

## Test plan
- Reset, then one cache transaction (D0=0xA, D1=0xB, rsp cmd tag 5) -> data 0xA/0xB at T+2, response tag 5 at T+2+RSP_GAP, nothing else valid.
- Both sources eligible every cycle for 8 cycles with RR_EN defined -> grants alternate cache, mem, cache, …; each source gets 4 grants.
- Same stimulus with RR_EN undefined -> all 8 grants go to cache; mem is served only after cache drains.
- stall_in held high for 10 cycles with FIFO_DEPTH=16 and 14 cache pushes -> cache_full_out=1 after the count reaches 14. A 17th push sets overflow_out. After stall release, exactly 16 transactions emerge in order.
- Response pushed 3 cycles before its data halves -> no grant until D0 and D1 arrive; data is output before the response.
- rstn_in low for 1 cycle with 3 transactions in the RSP pipeline -> no response valid afterwards; the next new transaction is output normally.

Source files
------------

// File: rtl/cu_vertex_cache_response_merge_if.sv
// rtl/cu_vertex_cache_response_merge_if.sv - payload types and stream bundle for the vertex cache response merge
package cu_vertex_cache_response_merge_pkg;

  typedef struct packed {
    logic        valid;
    logic [7:0]  cmd_tag;
    logic [23:0] vertex_id;
  } ResponseBufferLine;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
  } ReadWriteDataLine;

endpackage

interface cu_vertex_cache_response_merge_if;
  import cu_vertex_cache_response_merge_pkg::*;

  logic              enabled_in;
  logic              stall_in;
  ResponseBufferLine cache_response_in;
  ReadWriteDataLine  cache_data_0_in;
  ReadWriteDataLine  cache_data_1_in;
  ResponseBufferLine mem_response_in;
  ReadWriteDataLine  mem_data_0_in;
  ReadWriteDataLine  mem_data_1_in;
  ResponseBufferLine read_response_out;
  ReadWriteDataLine  read_data_0_out;
  ReadWriteDataLine  read_data_1_out;
  logic              cache_full_out;
  logic              mem_full_out;
  logic              overflow_out;

  modport master (
    output enabled_in, stall_in,
    output cache_response_in, cache_data_0_in, cache_data_1_in,
    output mem_response_in, mem_data_0_in, mem_data_1_in,
    input  read_response_out, read_data_0_out, read_data_1_out,
    input  cache_full_out, mem_full_out, overflow_out
  );

  modport slave (
    input  enabled_in, stall_in,
    input  cache_response_in, cache_data_0_in, cache_data_1_in,
    input  mem_response_in, mem_data_0_in, mem_data_1_in,
    output read_response_out, read_data_0_out, read_data_1_out,
    output cache_full_out, mem_full_out, overflow_out
  );

endinterface

// File: rtl/cu_vertex_cache_response_merge.sv
// rtl/cu_vertex_cache_response_merge.sv - merges cache-hit and memory-read streams; round-robin when VERTEX_CACHE_MERGE_RR_EN is defined
module cu_vertex_cache_response_merge_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clock,
  input  logic                   rstn_in,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   drop
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // A pop frees the slot being written, so a full FIFO may still take a push alongside a pop.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign drop    = push && full && !pop;
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clock) begin
    if (!rstn_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  // Payload storage; contents are don't-care until the count covers them.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

module cu_vertex_cache_response_merge
  import cu_vertex_cache_response_merge_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int RSP_GAP    = 4
) (
  input logic                           clock,
  input logic                           rstn_in,
  cu_vertex_cache_response_merge_if.slave bus
);
  localparam int               CW       = $clog2(FIFO_DEPTH) + 1;
  localparam int               RSP_W    = $bits(ResponseBufferLine);
  localparam int               DAT_W    = $bits(ReadWriteDataLine);
  localparam logic [CW-1:0]    AF_LEVEL = CW'(FIFO_DEPTH - 2);

  // Source index 0 is the cache-hit path, index 1 the memory-read path.
  ResponseBufferLine rsp_in   [2];
  ReadWriteDataLine  d0_in    [2];
  ReadWriteDataLine  d1_in    [2];
  ResponseBufferLine rsp_head [2];
  ReadWriteDataLine  d0_head  [2];
  ReadWriteDataLine  d1_head  [2];
  logic [CW-1:0]     rsp_count [2];
  logic [CW-1:0]     d0_count  [2];
  logic [CW-1:0]     d1_count  [2];
  logic [1:0]        rsp_empty, d0_empty, d1_empty;
  logic [1:0]        rsp_drop, d0_drop, d1_drop;
  logic [1:0]        eligible;
  logic [1:0]        pop;
  logic              grant;
  logic              win;
  ResponseBufferLine sel_rsp;
  ReadWriteDataLine  sel_d0;
  ReadWriteDataLine  sel_d1;
  ResponseBufferLine rsp_pipe [RSP_GAP];

  assign rsp_in[0] = bus.cache_response_in;
  assign rsp_in[1] = bus.mem_response_in;
  assign d0_in[0]  = bus.cache_data_0_in;
  assign d0_in[1]  = bus.mem_data_0_in;
  assign d1_in[0]  = bus.cache_data_1_in;
  assign d1_in[1]  = bus.mem_data_1_in;

  for (genvar s = 0; s < 2; s++) begin : g_src
    cu_vertex_cache_response_merge_fifo #(.WIDTH(RSP_W), .DEPTH(FIFO_DEPTH)) u_rsp (
      .clock(clock), .rstn_in(rstn_in), .push(rsp_in[s].valid), .pop(pop[s]),
      .wdata(rsp_in[s]), .rdata(rsp_head[s]), .empty(rsp_empty[s]),
      .count(rsp_count[s]), .drop(rsp_drop[s])
    );
    cu_vertex_cache_response_merge_fifo #(.WIDTH(DAT_W), .DEPTH(FIFO_DEPTH)) u_d0 (
      .clock(clock), .rstn_in(rstn_in), .push(d0_in[s].valid), .pop(pop[s]),
      .wdata(d0_in[s]), .rdata(d0_head[s]), .empty(d0_empty[s]),
      .count(d0_count[s]), .drop(d0_drop[s])
    );
    cu_vertex_cache_response_merge_fifo #(.WIDTH(DAT_W), .DEPTH(FIFO_DEPTH)) u_d1 (
      .clock(clock), .rstn_in(rstn_in), .push(d1_in[s].valid), .pop(pop[s]),
      .wdata(d1_in[s]), .rdata(d1_head[s]), .empty(d1_empty[s]),
      .count(d1_count[s]), .drop(d1_drop[s])
    );
  end

  // A source can only be granted as a complete transaction: response plus both halves.
  assign eligible = ~rsp_empty & ~d0_empty & ~d1_empty;

`ifdef VERTEX_CACHE_MERGE_RR_EN
  logic rr_prio_mem;

  // After each grant, priority moves to the source that did not just win.
  always_ff @(posedge clock) begin
    if (!rstn_in)   rr_prio_mem <= 1'b0;
    else if (grant) rr_prio_mem <= ~win;
  end
`endif

  // Pick the winning source and form the popped transaction.
  always_comb begin
    grant = 1'b0;
    win   = 1'b0;
    pop   = '0;
    if (bus.enabled_in && !bus.stall_in && (|eligible)) begin
      grant = 1'b1;
`ifdef VERTEX_CACHE_MERGE_RR_EN
      win   = eligible[1] & (~eligible[0] | rr_prio_mem);
`else
      win   = ~eligible[0];
`endif
      pop[win] = 1'b1;
    end
    sel_rsp       = grant ? rsp_head[win] : '0;
    sel_d0        = grant ? d0_head[win]  : '0;
    sel_d1        = grant ? d1_head[win]  : '0;
    sel_rsp.valid = grant;
    sel_d0.valid  = grant;
    sel_d1.valid  = grant;
  end

  // Data leaves at once; the response trails through a free-running delay line so it never overtakes its data.
  always_ff @(posedge clock) begin
    if (!rstn_in) begin
      bus.read_data_0_out   <= '0;
      bus.read_data_1_out   <= '0;
      bus.read_response_out <= '0;
      for (int i = 0; i < RSP_GAP; i++) rsp_pipe[i] <= '0;
    end else begin
      bus.read_data_0_out   <= sel_d0;
      bus.read_data_1_out   <= sel_d1;
      rsp_pipe[0]           <= sel_rsp;
      for (int i = 1; i < RSP_GAP; i++) rsp_pipe[i] <= rsp_pipe[i-1];
      bus.read_response_out <= rsp_pipe[RSP_GAP-1];
    end
  end

  // Almost-full flags leave a two-entry margin for upstream latency; overflow is sticky.
  always_ff @(posedge clock) begin
    if (!rstn_in) begin
      bus.cache_full_out <= 1'b0;
      bus.mem_full_out   <= 1'b0;
      bus.overflow_out   <= 1'b0;
    end else begin
      bus.cache_full_out <= (rsp_count[0] >= AF_LEVEL) || (d0_count[0] >= AF_LEVEL) ||
                            (d1_count[0] >= AF_LEVEL);
      bus.mem_full_out   <= (rsp_count[1] >= AF_LEVEL) || (d0_count[1] >= AF_LEVEL) ||
                            (d1_count[1] >= AF_LEVEL);
      bus.overflow_out   <= bus.overflow_out | (|rsp_drop) | (|d0_drop) | (|d1_drop);
    end
  end
endmodule
